// File: rtl/render_pkg.sv
// Shared render types: signed 3.5 fixed point, saturating add,
// and the ray sample generator state encoding.
package render_pkg;

  typedef logic signed [7:0] fx35_t;

  localparam fx35_t FX35_MAX = 8'sh7F;
  localparam fx35_t FX35_MIN = 8'sh80;

  typedef enum logic {
    IDLE,
    RUN
  } rsg_state_e;

  function automatic fx35_t sat_add_fx35(
    input fx35_t a,
    input fx35_t b
  );
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    // Sign bit and bit 7 disagree only on overflow
    case (s[8:7])
      2'b01:   return FX35_MAX;
      2'b10:   return FX35_MIN;
      default: return fx35_t'(s[7:0]);
    endcase
  endfunction

endpackage

// File: rtl/ray_sample_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1.
// Shifts right; feedback enters at bit 15.
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] value
);

  logic fb;

  assign fb = value[0] ^ value[2] ^ value[3] ^ value[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 16'hACE1;
    end else if (advance) begin
      value <= {fb, value[15:1]};
    end
  end

endmodule

// File: rtl/ray_sample_gen.sv
// Ray sample distance generator feeding the spacing LUT stage.
// Define RAY_SAMPLE_JITTER_EN to add 0..3 LSB LFSR jitter to s_data.
module ray_sample_gen
  import render_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 6,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_t_start,
  input  logic [DATA_W-1:0] req_step,
  input  logic [CNT_W-1:0]  req_count,
  input  logic [ID_W-1:0]   req_id,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last,
  output logic [ID_W-1:0]   s_id,
  output logic              busy
);

  rsg_state_e state, state_d;

  fx35_t            acc, acc_d;
  fx35_t            step_q, step_d;
  fx35_t            data_q, data_d;
  fx35_t            nv;
  logic [CNT_W-1:0] rem, rem_d;
  logic             ready_d;
  logic             valid_d;
  logic             last_d;
  logic [ID_W-1:0]  id_d;
  logic             take;
  logic             beat;
  logic             load;

  assign take = (state == IDLE) && req_valid && req_ready;
  assign beat = (state == RUN) && s_valid && s_ready;

`ifdef RAY_SAMPLE_JITTER_EN
  logic [15:0] lfsr;
  logic        adv;

  // Advance on every emitted or retired sample, jitter uses pre-advance value
  assign adv = (take && (req_count != '0)) || beat;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (adv),
    .value   (lfsr)
  );
`endif

  always_comb begin
    state_d = state;
    acc_d   = acc;
    step_d  = step_q;
    rem_d   = rem;
    ready_d = req_ready;
    valid_d = s_valid;
    last_d  = s_last;
    id_d    = s_id;
    data_d  = data_q;
    nv      = acc;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_d = 1'b1;
        if (take && (req_count != '0)) begin
          nv      = fx35_t'(req_t_start);
          load    = 1'b1;
          acc_d   = nv;
          step_d  = fx35_t'(req_step);
          rem_d   = req_count;
          valid_d = 1'b1;
          id_d    = req_id;
          last_d  = (req_count == CNT_W'(1));
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat) begin
          if (s_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            nv     = sat_add_fx35(acc, step_q);
            load   = 1'b1;
            acc_d  = nv;
            rem_d  = rem - CNT_W'(1);
            last_d = (rem == CNT_W'(2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
`ifdef RAY_SAMPLE_JITTER_EN
      data_d = sat_add_fx35(nv, fx35_t'({6'b0, lfsr[1:0]}));
`else
      data_d = nv;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      step_q    <= '0;
      rem       <= '0;
      req_ready <= 1'b0;
      s_valid   <= 1'b0;
      s_last    <= 1'b0;
      s_id      <= '0;
      data_q    <= '0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      step_q    <= step_d;
      rem       <= rem_d;
      req_ready <= ready_d;
      s_valid   <= valid_d;
      s_last    <= last_d;
      s_id      <= id_d;
      data_q    <= data_d;
    end
  end

  assign s_data = DATA_W'(data_q);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ray_sample_gen.sv
// Scoreboard bench for ray_sample_gen: directed rays, stalls,
// empty ray, mid-ray reset; jitter model when RAY_SAMPLE_JITTER_EN set.
module tb_ray_sample_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_t_start = '0;
  logic [7:0] req_step = '0;
  logic [5:0] req_count = '0;
  logic [3:0] req_id = '0;
  logic       s_valid;
  logic       s_ready = 1'b1;
  logic [7:0] s_data;
  logic       s_last;
  logic [3:0] s_id;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [3:0] id;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] lfsr_m = 16'hACE1;

  always #5 clk = ~clk;

  ray_sample_gen #(
    .DATA_W (8),
    .CNT_W  (6),
    .ID_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_t_start (req_t_start),
    .req_step    (req_step),
    .req_count   (req_count),
    .req_id      (req_id),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_id        (s_id),
    .busy        (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] a,
                                     input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  task automatic push_ray(input logic [7:0] st, input logic [7:0] sp,
                          input int cnt, input logic [3:0] id);
    logic [7:0] acc;
    exp_t e;
    acc = st;
    for (int i = 0; i < cnt; i++) begin
      e.d = acc;
`ifdef RAY_SAMPLE_JITTER_EN
      e.d = sat(acc, {6'b0, lfsr_m[1:0]});
      lfsr_m = lstep(lfsr_m);
`endif
      e.l = (i == cnt - 1);
      e.id = id;
      q.push_back(e);
      acc = sat(acc, sp);
    end
`ifdef RAY_SAMPLE_JITTER_EN
    if (cnt > 0) lfsr_m = lstep(lfsr_m);
`endif
  endtask

  task automatic issue(input logic [7:0] st, input logic [7:0] sp,
                       input int cnt, input logic [3:0] id);
    req_t_start = st;
    req_step = sp;
    req_count = 6'(cnt);
    req_id = id;
    req_valid = 1'b1;
    push_ray(st, sp, cnt, id);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_t_start = 8'h5A;
    req_step = 8'h3C;
    req_count = 6'd9;
    req_id = 4'hF;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && req_ready) break;
      @(posedge clk); #1;
    end
    chk("drain", {31'b0, (q.size() == 0) && req_ready}, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && s_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_sample: got %0h expected none", s_data);
      end else begin
        chk("s_data", {24'b0, s_data}, {24'b0, q[0].d});
        chk("s_last", {31'b0, s_last}, {31'b0, q[0].l});
        chk("s_id", {28'b0, s_id}, {28'b0, q[0].id});
        if (s_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_s_valid", {31'b0, s_valid}, 0);
    chk("rst_s_last", {31'b0, s_last}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_s_data", {24'b0, s_data}, 0);
    chk("rst_s_id", {28'b0, s_id}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", {31'b0, req_ready}, 0);
    @(posedge clk); #1;
    chk("ready_after_release", {31'b0, req_ready}, 1);

    // basic ray and ready latency
    issue(8'h00, 8'h08, 4, 4'd3);
    chk("t1_busy", {31'b0, busy}, 1);
    chk("t1_ready_low", {31'b0, req_ready}, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t1_ready_before_last", {31'b0, req_ready}, 0);
    @(posedge clk); #1;
    chk("t1_ready_after_last", {31'b0, req_ready}, 1);
    chk("t1_busy_done", {31'b0, busy}, 0);
    chk("t1_valid_done", {31'b0, s_valid}, 0);
    chk("t1_beats", q.size(), 0);

    // saturation both directions
    wait_idle();
    issue(8'h70, 8'h08, 4, 4'd1);
    wait_idle();
    issue(8'h88, 8'hF8, 3, 4'd2);
    wait_idle();

    // back-pressure
    issue(8'h00, 8'h08, 4, 4'd3);
    for (int i = 0; i < 7; i++) begin
      s_ready = pat[i][0];
      @(posedge clk); #1;
    end
    s_ready = 1'b1;
    chk("t3_ready", {31'b0, req_ready}, 1);
    chk("t3_beats", q.size(), 0);

    // empty ray
    wait_idle();
    req_t_start = 8'h33;
    req_step = 8'h01;
    req_count = 6'd0;
    req_id = 4'd7;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_valid", {31'b0, s_valid}, 0);
    chk("t4_busy", {31'b0, busy}, 0);
    chk("t4_ready", {31'b0, req_ready}, 1);
    repeat (2) begin @(posedge clk); #1; end
    chk("t4_valid_later", {31'b0, s_valid}, 0);
    chk("t4_ready_later", {31'b0, req_ready}, 1);

    // reset mid-ray
    issue(8'h00, 8'h10, 8, 4'd6);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    q.delete();
    lfsr_m = 16'hACE1;
    #1;
    chk("t5_valid", {31'b0, s_valid}, 0);
    chk("t5_last", {31'b0, s_last}, 0);
    chk("t5_ready", {31'b0, req_ready}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_data", {24'b0, s_data}, 0);
    chk("t5_id", {28'b0, s_id}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_ready_release", {31'b0, req_ready}, 0);
    @(posedge clk); #1;
    chk("t5_ready_edge", {31'b0, req_ready}, 1);
    issue(8'h20, 8'h01, 3, 4'd5);
    wait_idle();
    chk("final_queue", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
